// File: rtl/aritmetica_pkg.sv
// Shared arithmetic datapath definitions: the 5-bit width, the divider iteration
// count and the divider FSM state type.
package aritmetica_pkg;
  localparam int unsigned ANCHO  = 5;
  localparam int unsigned N_ITER = 5;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } estado_t;
endpackage

// File: rtl/divisor_secuencial_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
interface divisor_secuencial_if;
  logic                             start;
  logic [aritmetica_pkg::ANCHO-1:0] dividendo;
  logic [aritmetica_pkg::ANCHO-1:0] divisor;
  logic [aritmetica_pkg::ANCHO-1:0] cociente;
  logic [aritmetica_pkg::ANCHO-1:0] residuo;
  logic                             busy;
  logic                             done;
  logic                             div_cero;

  modport master (
    output start, dividendo, divisor,
    input  cociente, residuo, busy, done, div_cero
  );

  modport slave (
    input  start, dividendo, divisor,
    output cociente, residuo, busy, done, div_cero
  );
endinterface

// File: rtl/Restador.sv
// 5-bit two's-complement subtractor: restador = minuendo - sustraendo,
// C_out = 1 when no borrow occurs (minuendo >= sustraendo, sustraendo nonzero).
module Restador
  import aritmetica_pkg::*;
(
  input  logic [ANCHO-1:0] minuendo,
  input  logic [ANCHO-1:0] sustraendo,
  output logic [ANCHO-1:0] restador,
  output logic             C_out
);
  logic [ANCHO:0] suma;

  assign suma     = {1'b0, minuendo} + {1'b0, ~sustraendo} + {{ANCHO{1'b0}}, 1'b1};
  assign restador = suma[ANCHO-1:0];
  // A zero subtrahend always carries with carry-in 1; masked so a zero divisor never sets a quotient bit.
  assign C_out    = suma[ANCHO] & (|sustraendo);
endmodule

// File: rtl/divisor_secuencial.sv
// Sequential 5-bit restoring divider, one quotient bit per clock via Restador.
// Optional macro DIVISOR_DIVCERO_EN: short-circuit divide-by-zero with div_cero flag.
module divisor_secuencial
  import aritmetica_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  divisor_secuencial_if.slave  bus
);
  estado_t          estado, estado_sig;
  logic [CNT_W-1:0] cnt;
  logic [ANCHO-1:0] r, q, dvd, dsr;
  logic [ANCHO-1:0] t, dif;
  logic             c_out;
  logic             cero;
  logic             dz;

`ifdef DIVISOR_DIVCERO_EN
  assign cero = (bus.divisor == '0);
`else
  assign cero = 1'b0;
`endif

  // Dividend copy shifts left so its MSB is always the next bit to bring down.
  assign t = {r[ANCHO-2:0], dvd[ANCHO-1]};

  Restador u_restador (
    .minuendo   (t),
    .sustraendo (dsr),
    .restador   (dif),
    .C_out      (c_out)
  );

  always_ff @(posedge clk) begin
    if (rst) estado <= IDLE;
    else     estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      IDLE:    if (bus.start) estado_sig = cero ? FIN : CALC;
      CALC:    if (cnt == CNT_W'(N_ITER - 1)) estado_sig = FIN;
      FIN:     estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (estado != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      r            <= '0;
      q            <= '0;
      dvd          <= '0;
      dsr          <= '0;
      dz           <= 1'b0;
      bus.cociente <= '0;
      bus.residuo  <= '0;
      bus.done     <= 1'b0;
      bus.div_cero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (estado)
        IDLE: begin
          if (bus.start) begin
            dvd <= bus.dividendo;
            dsr <= bus.divisor;
            cnt <= '0;
            // Divide-by-zero preloads the final results so FIN can publish them directly.
            r   <= cero ? bus.dividendo : '0;
            q   <= cero ? '1 : '0;
            dz  <= cero;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          dvd <= {dvd[ANCHO-2:0], 1'b0};
          r   <= c_out ? dif : t;
          q   <= {q[ANCHO-2:0], c_out};
        end
        FIN: begin
          bus.cociente <= q;
          bus.residuo  <= r;
          bus.div_cero <= dz;
          bus.done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/divisor_secuencial.md
# divisor_secuencial

Sequential 5-bit unsigned restoring divider built directly around the team's 5-bit two's-complement subtractor. It drives the subtractor's minuend and subtrahend every cycle and consumes its difference and carry-out to decide each quotient bit, producing one quotient bit per clock. It runs as a start/busy/done coprocessor stage beside the subtractor in the arithmetic datapath.

## Interface
Parameters:
- none. Width is fixed at 5 bits to match the subtractor.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request a division. Sampled only in IDLE.
- `dividendo`  in  5  unsigned dividend, captured on accepted start.
- `divisor`  in  5  unsigned divisor, captured on accepted start.
- `cociente`  out  5  quotient, registered.
- `residuo`  out  5  remainder, registered.
- `busy`  out  1  high while a division is in progress (CALC).
- `done`  out  1  one-cycle pulse when results are valid.
- `div_cero`  out  1  divide-by-zero flag, registered.

## Operation
- **Reset values.** All outputs are 0. State is IDLE, the iteration counter is 0, and the internal partial remainder, quotient shift register and operand copies are 0.
- **States:**
  - **IDLE.** If `start` is high, latch `dividendo`/`divisor`, clear partial remainder R and counter, and go to CALC. Otherwise stay in IDLE.
  - **CALC.** Runs exactly 5 iterations, MSB of dividend first, counter 0..4. Each iteration:
    - T = {R[3:0], next dividend bit}.
    - Subtractor inputs are minuendo=T, sustraendo=latched divisor.
    - If the subtractor carry-out is 1 (T ≥ divisor, divisor ≠ 0), then R ← difference and the quotient bit is 1.
    - Otherwise R ← T and the quotient bit is 0.
    - After iteration 4, go to FIN.
  - **FIN.** Load `cociente`/`residuo`, pulse `done`, return to IDLE.
- **Width rule.** After k iterations, R < 2^k and R < divisor. The shifted T therefore always fits in 5 bits, and no overflow bit is needed.
- **Output hold.** `cociente`, `residuo` and `div_cero` hold their values from FIN until the next FIN or `rst`.
- **Ignored start.** `start` is ignored in CALC and FIN. There is no queueing.
- **Reset mid-operation.** `rst` has priority in any state and returns everything to reset values on the next edge. A division in flight is discarded with no `done`.

## Timing
- `start` sampled high at edge 0 → `busy`=1 from edge 0 through edge 5.
- CALC iterations execute at edges 1..5.
- FIN at edge 6: `done`=1 and valid results for exactly the cycle after edge 6. `busy`=0 in that cycle.
- Fixed latency is 6 cycles from an accepted start to `done`. Throughput is one division per 7 cycles; the earliest next accepted `start` is the cycle `done` is high, since the block is in IDLE then.
- `start` held high continuously starts a new division each time the block enters IDLE.

## Configuration
- `DIVISOR_DIVCERO_EN` defined:
  - A divisor of 0 is detected in IDLE on start.
  - The block skips CALC and goes directly to FIN, so `done` comes 1 cycle after the accepted start.
  - Results are `cociente`=31, `residuo`=dividendo, `div_cero`=1.
  - `div_cero`=0 for every nonzero divisor.
- Not defined:
  - `div_cero` is tied to 0.
  - A divisor of 0 runs the normal 5 iterations. The carry-out is always 0, so the results are `cociente`=0 and `residuo`=dividendo, with `done` at 6 cycles.

## Structure
- **Shared package** `aritmetica_pkg` holds:
  - width constant `ANCHO`=5;
  - iteration count `N_ITER`=5;
  - state enum `IDLE`, `CALC`, `FIN`.
- **Sub-module** is one instance of the existing 5-bit subtractor `Restador`, with inputs minuendo=T and sustraendo=divisor. Its outputs `restador` and `C_out` feed the R update and the quotient bit.
- The FSM, 3-bit counter and shift registers live in the top module.

## Test plan
- 23 / 5, start one cycle → `done` exactly 6 cycles later; `cociente`=4, `residuo`=3; `busy` high for 6 cycles.
- 31 / 1 → 31 r 0; 7 / 9 → 0 r 7; 31 / 31 → 1 r 0; 31 / 17 → 1 r 14. Back-to-back starts are asserted in each `done` cycle.
- 12 / 0 with `DIVISOR_DIVCERO_EN` → `done` 1 cycle after start; results 31 r 12, `div_cero`=1. Without the macro → `done` at 6 cycles; results 0 r 12, `div_cero`=0.
- `start` pulsed with 9 / 2 during CALC of an in-flight 23 / 5 → only one `done`, with results 4 r 3.
- `rst` asserted at iteration 2 of 23 / 5 → next cycle all outputs 0 and state IDLE, with no `done`. A new 20 / 4 afterwards → 5 r 0.
- Random sweep of all 32×31 nonzero-divisor pairs → results match the integer `/` and `%` reference, each with 6-cycle latency.
